tone_scheduler: RTL and testbench
=================================

TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4: tone request queue entries (power of two, 2..16).
REQ-002 SHALL have parameter GOOD_CYC, default 3000000: cycles a good tone is held busy after its fire pulse.
REQ-003 SHALL have parameter BAD_CYC, default 10000000: cycles a bad tone is held busy after its fire pulse.
REQ-004 SHALL have parameter GAP_CYC, default 120000: silent cycles between consecutive tones (0 legal).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port good_req  input  1  good-collision event, one-cycle pulse.
REQ-008 SHALL have port bad_req  input  1  bad-collision event, one-cycle pulse.
REQ-009 SHALL have port mute  input  1  level; blocks enqueue and firing.
REQ-010 SHALL have port goodColl  output  1  one-cycle trigger to oscillator, good tone.
REQ-011 SHALL have port badColl  output  1  one-cycle trigger to oscillator, bad tone.
REQ-012 SHALL have port busy  output  1  high whenever FSM not IDLE.
REQ-013 SHALL have port q_count  output  $clog2(DEPTH)+1  queued entries.
REQ-014 SHALL have port dropped  output  1  one-cycle pulse when any request is discarded.

Function
REQ-015 SHALL implement FSM states IDLE, FIRE, PLAY, GAP.
REQ-016 IDLE -> FIRE at an edge where queue non-empty and mute low; head popped at that edge and its tone type latched.
REQ-017 FIRE SHALL last exactly 1 cycle, during which exactly one of goodColl/badColl is high, matching latched type; both low in all other states.
REQ-018 PLAY SHALL last exactly GOOD_CYC or BAD_CYC cycles per latched type, counted by a 24-bit down-counter.
REQ-019 PLAY -> GAP if GAP_CYC>0, else directly to IDLE; GAP lasts exactly GAP_CYC cycles then -> IDLE.
REQ-020 Latency: request sampled at edge E with idle FSM and empty queue -> trigger output high from edge E+1 to E+2.
REQ-021 Request sampled with mute low and queue not full SHALL be enqueued at that edge; otherwise discarded and dropped pulses next cycle.
REQ-022 good_req and bad_req together: bad enqueued ahead of good; if only one slot free, bad kept, good discarded (dropped pulses).
REQ-023 Push and pop at same edge SHALL both occur; q_count unchanged; push to full queue with simultaneous pop SHALL succeed.
REQ-024 Queue SHALL be FIFO; pointers wrap modulo DEPTH; q_count never exceeds DEPTH nor underflows.
REQ-025 mute rising SHALL flush queue at that edge (q_count 0 next cycle) without asserting dropped; a tone already in PLAY/GAP completes its timing.
REQ-026 Requests during FIRE/PLAY/GAP SHALL queue, never interrupt current tone.

Reset
REQ-027 rst high at an edge SHALL force IDLE, empty queue, counter 0, latched type good, all outputs 0, from next cycle.
REQ-028 rst mid-PLAY/GAP SHALL abandon tone immediately; no trigger issued in the cycle after rst deasserts.
REQ-029 Requests sampled while rst high SHALL be ignored, dropped stays 0.

Structure
REQ-030 Shared package SHALL hold tone_t (TONE_GOOD, TONE_BAD), sched_state_t enum, and default duration constants (FPGA 12 MHz values, final-chip 10 MHz values).
REQ-031 Queue SHALL be sub-module tone_fifo (parameter DEPTH, 1-entry tone_t data, push/pop/full/empty/count).
REQ-032 All outputs SHALL be registered.

Verification (GOOD_CYC=8, BAD_CYC=20, GAP_CYC=4, DEPTH=4)
REQ-033 Single good_req at edge 10 -> goodColl high cycle 11 only; busy high 11..23; idle from 24.
REQ-034 good_req+bad_req same edge, idle -> badColl pulse, 20 PLAY, 4 GAP, 1 IDLE, then goodColl pulse; dropped never high.
REQ-035 Six good_req consecutive cycles while busy with bad tone -> q_count reaches 4, dropped pulses twice, exactly 4 later goodColl pulses.
REQ-036 mute high with 3 queued, then low -> q_count 0, no triggers, dropped 0; requests during mute -> dropped pulses each.
REQ-037 rst during PLAY cycle 5 -> busy 0, q_count 0 next cycle; no triggers until new request.
REQ-038 Push at full with pop same edge (IDLE->FIRE) -> accepted, q_count stays 4, dropped 0.

Source files
------------

// File: rtl/tone_scheduler_pkg.sv
// rtl/tone_scheduler_pkg.sv - shared types and default tone durations for tone_scheduler
package tone_scheduler_pkg;

    typedef enum logic {
        TONE_GOOD = 1'b0,
        TONE_BAD  = 1'b1
    } tone_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int CNT_W = 24;

    // FPGA board clock, 12 MHz
    localparam int FPGA_GOOD_CYC = 3000000;
    localparam int FPGA_BAD_CYC  = 10000000;
    localparam int FPGA_GAP_CYC  = 120000;

    // final chip clock, 10 MHz
    localparam int CHIP_GOOD_CYC = 2500000;
    localparam int CHIP_BAD_CYC  = 8333333;
    localparam int CHIP_GAP_CYC  = 100000;

    // down-counter reload so that a phase of cyc cycles ends when the counter reads zero
    function automatic logic [CNT_W-1:0] load_val(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/tone_fifo.sv
// rtl/tone_fifo.sv - tone request queue, up to two pushes and one pop per cycle
module tone_fifo
    import tone_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push0,
    input  tone_t                    data0,
    input  logic                     push1,
    input  tone_t                    data1,
    input  logic                     pop,
    output tone_t                    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    tone_t         mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // push1 always lands in the slot after push0; the caller never raises push1 alone
    always_ff @(posedge clk) begin
        if (push0) mem[wptr] <= data0;
        if (push1) mem[wptr + AW'(1)] <= data1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push0) + AW'(push1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - queues collision events and sequences good/bad tone triggers
module tone_scheduler
    import tone_scheduler_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int GOOD_CYC = FPGA_GOOD_CYC,
    parameter int BAD_CYC  = FPGA_BAD_CYC,
    parameter int GAP_CYC  = FPGA_GAP_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     good_req,
    input  logic                     bad_req,
    input  logic                     mute,
    output logic                     goodColl,
    output logic                     badColl,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     dropped
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t      state;
    sched_state_t      state_nxt;
    tone_t             tone_q;
    tone_t             head;
    logic [CNT_W-1:0]  cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CW-1:0]     free_slots;
    logic              slot1_ok;
    logic              slot2_ok;
    logic              bad_acc;
    logic              good_acc;
    logic              good_nxt;
    logic              bad_nxt;
    logic              busy_nxt;
    logic              drop_nxt;

    assign pop = (state == IDLE) && !fifo_empty && !mute;

    // a pop in the same cycle frees a slot, so a full queue still accepts one push
    always_comb begin
        free_slots = CW'(DEPTH) - q_count + CW'(pop);
        slot1_ok   = !fifo_full || pop;
        slot2_ok   = (free_slots >= CW'(2));
        bad_acc    = bad_req && !mute && slot1_ok;
        good_acc   = good_req && !mute && (bad_acc ? slot2_ok : slot1_ok);
    end

    tone_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (mute),
        .push0 (bad_acc || good_acc),
        .data0 (bad_acc ? TONE_BAD : TONE_GOOD),
        .push1 (bad_acc && good_acc),
        .data1 (TONE_GOOD),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tone_q <= TONE_GOOD;
        end else begin
            state <= state_nxt;
            if (pop) tone_q <= head;
            unique case (state)
                FIRE:      cnt <= load_val((tone_q == TONE_BAD) ? BAD_CYC : GOOD_CYC);
                PLAY, GAP: cnt <= (cnt != '0) ? cnt - CNT_W'(1) :
                                  ((state == PLAY) && (GAP_CYC > 0)) ? load_val(GAP_CYC) : '0;
                default:   cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pop) state_nxt = FIRE;
            FIRE:    state_nxt = PLAY;
            PLAY:    if (cnt == '0) state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
            GAP:     if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIRE is only entered on a pop, so the head entry is the tone being fired
    always_comb begin
        good_nxt = (state_nxt == FIRE) && (head == TONE_GOOD);
        bad_nxt  = (state_nxt == FIRE) && (head == TONE_BAD);
        busy_nxt = (state_nxt != IDLE);
        drop_nxt = (good_req && !good_acc) || (bad_req && !bad_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            goodColl <= good_nxt;
            badColl  <= bad_nxt;
            busy     <= busy_nxt;
            dropped  <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb/tb_tone_scheduler.sv - self-checking bench for tone_scheduler
module tb_tone_scheduler;

    localparam int DEPTH    = 4;
    localparam int GOOD_CYC = 8;
    localparam int BAD_CYC  = 20;
    localparam int GAP_CYC  = 4;

    logic       clk;
    logic       rst;
    logic       good_req;
    logic       bad_req;
    logic       mute;
    logic       goodColl;
    logic       badColl;
    logic       busy;
    logic [2:0] q_count;
    logic       dropped;

    int   total;
    int   bad;
    int   good_seen;
    int   bad_seen;
    int   drop_cnt;
    logic exp_q [$];

    tone_scheduler #(
        .DEPTH    (DEPTH),
        .GOOD_CYC (GOOD_CYC),
        .BAD_CYC  (BAD_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .good_req (good_req),
        .bad_req  (bad_req),
        .mute     (mute),
        .goodColl (goodColl),
        .badColl  (badColl),
        .busy     (busy),
        .q_count  (q_count),
        .dropped  (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: each trigger pulse pops the oldest expected tone (1 = bad)
    always @(negedge clk) begin
        if (goodColl) good_seen++;
        if (badColl) bad_seen++;
        if (dropped) drop_cnt++;
        if (goodColl || badColl) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL trig_unexpected goodColl=%0b badColl=%0b required none", goodColl, badColl);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if ((goodColl && badColl) || (badColl !== e)) begin
                    bad++;
                    $display("FAIL trig_type goodColl=%0b badColl=%0b required bad=%0b", goodColl, badColl, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0 && !busy && q_count == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; good_req = 1'b1; bad_req = 1'b0; mute = 1'b0;
        step();
        step();
        total++;
        if ({goodColl, badColl, busy, q_count, dropped} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=0000000", {goodColl, badColl, busy, q_count, dropped});
        end
        rst = 1'b0; good_req = 1'b0;
        step();
        total++;
        if (dropped !== 1'b0 || q_count !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_req_ignored dropped=%0b q_count=%0d busy=%0b required 0 0 0", dropped, q_count, busy);
        end
    endtask

    task automatic test_single();
        int d0;
        d0 = drop_cnt;
        good_req = 1'b1;
        exp_q.push_back(1'b0);
        step();
        good_req = 1'b0;
        total++;
        if (q_count !== 3'd1) begin
            bad++;
            $display("FAIL single_qcount got=%0d required=1", q_count);
        end
        for (int k = 1; k <= 15; k++) begin
            step();
            total++;
            if (goodColl !== (k == 1) || busy !== (k <= 13)) begin
                bad++;
                $display("FAIL single_timing k=%0d goodColl=%0b busy=%0b required %0b %0b", k, goodColl, busy, k == 1, k <= 13);
            end
        end
        total++;
        if (drop_cnt != d0) begin
            bad++;
            $display("FAIL single_dropped got=%0d required=0", drop_cnt - d0);
        end
    endtask

    task automatic test_both();
        int d0;
        d0 = drop_cnt;
        good_req = 1'b1; bad_req = 1'b1;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        step();
        good_req = 1'b0; bad_req = 1'b0;
        total++;
        if (q_count !== 3'd2) begin
            bad++;
            $display("FAIL both_qcount got=%0d required=2", q_count);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            total++;
            if (badColl !== (k == 1) || goodColl !== (k == 27) || busy !== (k != 26 && k != 40)) begin
                bad++;
                $display("FAIL both_timing k=%0d badColl=%0b goodColl=%0b busy=%0b", k, badColl, goodColl, busy);
            end
        end
        total++;
        if (drop_cnt != d0) begin
            bad++;
            $display("FAIL both_dropped got=%0d required=0", drop_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        int d0, g0;
        bit ok;
        d0 = drop_cnt; g0 = good_seen;
        bad_req = 1'b1;
        exp_q.push_back(1'b1);
        step();
        bad_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            good_req = 1'b1;
            if (i < 4) exp_q.push_back(1'b0);
            step();
            if (i == 3) begin
                total++;
                if (q_count !== 3'd4) begin
                    bad++;
                    $display("FAIL ovf_qcount got=%0d required=4", q_count);
                end
            end
        end
        good_req = 1'b0;
        wait_drain(400, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_drain_timeout pending=%0d required 0", exp_q.size());
        end
        total++;
        if (drop_cnt - d0 != 2 || good_seen - g0 != 4) begin
            bad++;
            $display("FAIL ovf_counts dropped=%0d goodColl=%0d required 2 4", drop_cnt - d0, good_seen - g0);
        end
    endtask

    task automatic test_mute();
        int d0, g0;
        bit ok;
        d0 = drop_cnt; g0 = good_seen;
        bad_req = 1'b1;
        exp_q.push_back(1'b1);
        step();
        bad_req = 1'b0;
        step();
        good_req = 1'b1;
        step();
        step();
        step();
        good_req = 1'b0;
        total++;
        if (q_count !== 3'd3) begin
            bad++;
            $display("FAIL mute_pre_qcount got=%0d required=3", q_count);
        end
        mute = 1'b1;
        step();
        total++;
        if (q_count !== 3'd0 || dropped !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mute_flush q_count=%0d dropped=%0b busy=%0b required 0 0 1", q_count, dropped, busy);
        end
        good_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dropped !== 1'b1) begin
                bad++;
                $display("FAIL mute_drop i=%0d got=%0b required=1", i, dropped);
            end
        end
        good_req = 1'b0;
        mute = 1'b0;
        wait_drain(200, ok);
        total++;
        if (!ok || good_seen != g0 || drop_cnt - d0 != 2) begin
            bad++;
            $display("FAIL mute_result ok=%0b goodColl=%0d dropped=%0d required 1 0 2", ok, good_seen - g0, drop_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        good_req = 1'b1;
        exp_q.push_back(1'b0);
        step();
        good_req = 1'b0;
        step();
        step();
        bad_req = 1'b1;
        step();
        bad_req = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || q_count !== 3'd0 || goodColl !== 1'b0 || badColl !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state busy=%0b q_count=%0d trig=%0b%0b required 0 0 00", busy, q_count, goodColl, badColl);
        end
        t0 = good_seen + bad_seen;
        for (int i = 0; i < 40; i++) step();
        total++;
        if (good_seen + bad_seen != t0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet triggers=%0d busy=%0b required 0 0", good_seen + bad_seen - t0, busy);
        end
    endtask

    task automatic test_full_pop();
        int d0;
        bit ok, idle;
        d0 = drop_cnt;
        bad_req = 1'b1;
        exp_q.push_back(1'b1);
        step();
        bad_req = 1'b0;
        good_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b0);
            step();
        end
        good_req = 1'b0;
        total++;
        if (q_count !== 3'd4) begin
            bad++;
            $display("FAIL fullpop_pre_qcount got=%0d required=4", q_count);
        end
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            step();
            idle = !busy;
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL fullpop_idle_timeout busy=%0b required 0", busy);
        end
        bad_req = 1'b1;
        exp_q.push_back(1'b1);
        step();
        bad_req = 1'b0;
        total++;
        if (q_count !== 3'd4 || dropped !== 1'b0 || goodColl !== 1'b1) begin
            bad++;
            $display("FAIL fullpop_edge q_count=%0d dropped=%0b goodColl=%0b required 4 0 1", q_count, dropped, goodColl);
        end
        wait_drain(400, ok);
        total++;
        if (!ok || drop_cnt != d0) begin
            bad++;
            $display("FAIL fullpop_drain ok=%0b dropped=%0d pending=%0d required 1 0 0", ok, drop_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        total = 0; bad = 0; good_seen = 0; bad_seen = 0; drop_cnt = 0;
        rst = 1'b1; good_req = 1'b0; bad_req = 1'b0; mute = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_overflow();
        test_mute();
        test_reset_mid();
        test_full_pop();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_pending got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
